// File: rtl/board_pkg.sv
// Shared definitions for the playfield command engine: geometry, command
// word layout, opcode/status/state encodings and an address range helper.
package board_pkg;

  localparam int unsigned ROWS    = 20;
  localparam int unsigned COLS    = 10;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned CMD_W   = 32;
  localparam int unsigned OP_W    = 3;

  // Command word field positions; [15:0] carries nothing.
  localparam int unsigned TOGGLE_BIT = 31;
  localparam int unsigned OP_LSB     = 28;
  localparam int unsigned ROW_LSB    = 23;
  localparam int unsigned COL_LSB    = 19;
  localparam int unsigned COLOR_LSB  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 3'd0,
    OP_WRITE_CELL  = 3'd1,
    OP_CLEAR_BOARD = 3'd2,
    OP_CLEAR_ROW   = 3'd3,
    OP_SHIFT_DOWN  = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    STAT_IDLE  = 2'b00,
    STAT_BUSY  = 2'b01,
    STAT_DONE  = 2'b10,
    STAT_ERROR = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_CLEAR      = 3'd2,
    S_CLR_ROW    = 3'd3,
    S_SHIFT_COPY = 3'd4,
    S_SHIFT_TOP  = 3'd5
  } state_e;

  // Upper half of the command word, [TOGGLE_BIT:COLOR_LSB].
  typedef struct packed {
    logic               toggle;
    logic [OP_W-1:0]    opcode;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  function automatic logic addr_ok(input logic [ROW_W-1:0] row,
                                   input logic [COL_W-1:0] col);
    return (row < ROW_W'(ROWS)) && (col < COL_W'(COLS));
  endfunction

endpackage

// File: rtl/board_store.sv
// Playfield cell array.
//   we_i/wr_*      : single write port, applied on the clock edge
//   cp_*           : combinational read port used by the row-collapse copy
//   rd_row/rd_col  : registered VGA read, 0 when out of range
//   full_rows_o    : registered per-row "all cells non-zero" flags
// Both registered outputs see the array as it was before the same-cycle write.
module board_store
  import board_pkg::*;
(
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               we_i,
  input  logic [ROW_W-1:0]   wr_row_i,
  input  logic [COL_W-1:0]   wr_col_i,
  input  logic [COLOR_W-1:0] wr_data_i,
  input  logic [ROW_W-1:0]   cp_row_i,
  input  logic [COL_W-1:0]   cp_col_i,
  output logic [COLOR_W-1:0] cp_data_c,
  input  logic [ROW_W-1:0]   rd_row_i,
  input  logic [COL_W-1:0]   rd_col_i,
  output logic [COLOR_W-1:0] rd_color_o,
  output logic [ROWS-1:0]    full_rows_o
);

  logic [COLOR_W-1:0] cells_q [ROWS][COLS];
  logic [COLOR_W-1:0] cells_d [ROWS][COLS];
  logic [COLOR_W-1:0] rd_color_q, rd_color_d;
  logic [ROWS-1:0]    full_rows_q, full_rows_d;

  // Write port; out-of-range addresses are dropped.
  always_comb begin
    cells_d = cells_q;
    if (we_i && addr_ok(wr_row_i, wr_col_i)) begin
      cells_d[wr_row_i][wr_col_i] = wr_data_i;
    end
  end

  assign cp_data_c = addr_ok(cp_row_i, cp_col_i) ? cells_q[cp_row_i][cp_col_i] : '0;

  // Read-side values taken from the pre-write array.
  always_comb begin
    rd_color_d = addr_ok(rd_row_i, rd_col_i) ? cells_q[rd_row_i][rd_col_i] : '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      full_rows_d[r] = 1'b1;
      for (int c = 0; c < int'(COLS); c++) begin
        if (cells_q[r][c] == '0) full_rows_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cells_q     <= '{default: '0};
      rd_color_q  <= '0;
      full_rows_q <= '0;
    end else begin
      cells_q     <= cells_d;
      rd_color_q  <= rd_color_d;
      full_rows_q <= full_rows_d;
    end
  end

  assign rd_color_o  = rd_color_q;
  assign full_rows_o = full_rows_q;

endmodule

// File: rtl/board_cmd_engine.sv
// Executes NIOS PIO command words against the 20x10 playfield.
//   block_data     : command word, accepted in IDLE when [31] differs from the
//                    last accepted toggle
//   drawing_status : 00 idle, 01 busy, 10 done, 11 error
//   rd_row/rd_col  : VGA read address; rd_color returns the cell one cycle later
//   full_rows      : per-row full flags
module board_cmd_engine
  import board_pkg::*;
(
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [CMD_W-1:0]   block_data,
  output logic [1:0]         drawing_status,
  input  logic [ROW_W-1:0]   rd_row,
  input  logic [COL_W-1:0]   rd_col,
  output logic [COLOR_W-1:0] rd_color,
  output logic [ROWS-1:0]    full_rows
);

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic               last_toggle_q, last_toggle_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ROW_W-1:0]   cnt_row_q, cnt_row_d;
  logic [COL_W-1:0]   cnt_col_q, cnt_col_d;

  cmd_t               cmd_c;
  logic               unused_low_c;
  logic               row_ok_c, col_last_c;
  logic               we_c;
  logic [ROW_W-1:0]   wr_row_c, cp_row_c;
  logic [COL_W-1:0]   wr_col_c;
  logic [COLOR_W-1:0] wr_data_c, cp_data_c;

  assign cmd_c        = cmd_t'(block_data[TOGGLE_BIT:COLOR_LSB]);
  assign unused_low_c = ^block_data[COLOR_LSB-1:0];
  assign row_ok_c     = cmd_c.row < ROW_W'(ROWS);
  assign col_last_c   = cnt_col_q == COL_W'(COLS - 1);

  // Collapse source is the row above the one being written.
  assign cp_row_c = cnt_row_q - ROW_W'(1);

  // Next-state, counters and write-port control.
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    last_toggle_d = last_toggle_q;
    row_d         = row_q;
    col_d         = col_q;
    color_d       = color_q;
    cnt_row_d     = cnt_row_q;
    cnt_col_d     = cnt_col_q;
    we_c          = 1'b0;
    wr_row_c      = cnt_row_q;
    wr_col_c      = cnt_col_q;
    wr_data_c     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_c.toggle != last_toggle_q) begin
          last_toggle_d = cmd_c.toggle;
          row_d         = cmd_c.row;
          col_d         = cmd_c.col;
          color_d       = cmd_c.color;
          cnt_row_d     = cmd_c.row;
          cnt_col_d     = '0;
          status_d      = STAT_BUSY;
          case (cmd_c.opcode)
            OP_NOP: status_d = STAT_DONE;
            OP_WRITE_CELL: begin
              if (addr_ok(cmd_c.row, cmd_c.col)) state_d = S_WRITE;
              else status_d = STAT_ERROR;
            end
            OP_CLEAR_BOARD: begin
              cnt_row_d = '0;
              state_d   = S_CLEAR;
            end
            OP_CLEAR_ROW: begin
              if (row_ok_c) state_d = S_CLR_ROW;
              else status_d = STAT_ERROR;
            end
            OP_SHIFT_DOWN: begin
              // Row 0 has nothing above it: go straight to zero-filling it.
              if (!row_ok_c) status_d = STAT_ERROR;
              else if (cmd_c.row == '0) state_d = S_SHIFT_TOP;
              else state_d = S_SHIFT_COPY;
            end
            default: status_d = STAT_ERROR;
          endcase
        end
      end

      S_WRITE: begin
        we_c      = 1'b1;
        wr_row_c  = row_q;
        wr_col_c  = col_q;
        wr_data_c = color_q;
        state_d   = S_IDLE;
        status_d  = STAT_DONE;
      end

      S_CLEAR: begin
        we_c = 1'b1;
        if (col_last_c) begin
          cnt_col_d = '0;
          if (cnt_row_q == ROW_W'(ROWS - 1)) begin
            state_d  = S_IDLE;
            status_d = STAT_DONE;
          end else begin
            cnt_row_d = cnt_row_q + ROW_W'(1);
          end
        end else begin
          cnt_col_d = cnt_col_q + COL_W'(1);
        end
      end

      S_CLR_ROW: begin
        we_c = 1'b1;
        if (col_last_c) begin
          state_d  = S_IDLE;
          status_d = STAT_DONE;
        end else begin
          cnt_col_d = cnt_col_q + COL_W'(1);
        end
      end

      S_SHIFT_COPY: begin
        we_c      = 1'b1;
        wr_data_c = cp_data_c;
        if (col_last_c) begin
          cnt_col_d = '0;
          cnt_row_d = cp_row_c;
          if (cnt_row_q == ROW_W'(1)) state_d = S_SHIFT_TOP;
        end else begin
          cnt_col_d = cnt_col_q + COL_W'(1);
        end
      end

      S_SHIFT_TOP: begin
        we_c     = 1'b1;
        wr_row_c = '0;
        if (col_last_c) begin
          state_d  = S_IDLE;
          status_d = STAT_DONE;
        end else begin
          cnt_col_d = cnt_col_q + COL_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= S_IDLE;
      status_q      <= STAT_IDLE;
      last_toggle_q <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      color_q       <= '0;
      cnt_row_q     <= '0;
      cnt_col_q     <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      last_toggle_q <= last_toggle_d;
      row_q         <= row_d;
      col_q         <= col_d;
      color_q       <= color_d;
      cnt_row_q     <= cnt_row_d;
      cnt_col_q     <= cnt_col_d;
    end
  end

  assign drawing_status = status_q;

  board_store u_store (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .we_i         (we_c),
    .wr_row_i     (wr_row_c),
    .wr_col_i     (wr_col_c),
    .wr_data_i    (wr_data_c),
    .cp_row_i     (cp_row_c),
    .cp_col_i     (cnt_col_q),
    .cp_data_c    (cp_data_c),
    .rd_row_i     (rd_row),
    .rd_col_i     (rd_col),
    .rd_color_o   (rd_color),
    .full_rows_o  (full_rows)
  );

endmodule

// File: tb/tb_board_cmd_engine.sv
// Self-checking bench for board_cmd_engine: a table of command words with
// expected final status and busy length, a behavioural playfield model, and
// hand-written sequences for toggle handling and mid-operation reset.
module tb_board_cmd_engine;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] block_data;
  logic [1:0]  drawing_status;
  logic [4:0]  rd_row;
  logic [3:0]  rd_col;
  logic [2:0]  rd_color;
  logic [19:0] full_rows;

  board_cmd_engine dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .block_data    (block_data),
    .drawing_status(drawing_status),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_color      (rd_color),
    .full_rows     (full_rows)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    string      name;
    logic [31:0] word;
    logic [1:0] st;
    int         busy;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] st;
    int         busy;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [2:0] model [20][10];
  bit         tgl;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit t, input int op, input int r,
                                     input int c, input int color);
    return {t, 3'(op), 5'(r), 4'(c), 3'(color), 16'h0};
  endfunction

  function automatic logic [31:0] next_word(input int op, input int r,
                                            input int c, input int color);
    tgl = ~tgl;
    return mk(tgl, op, r, c, color);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) model[r][c] = 3'd0;
  endtask

  task automatic model_apply(input logic [31:0] w);
    int op, r, c;
    op = int'(w[30:28]);
    r  = int'(w[27:23]);
    c  = int'(w[22:19]);
    case (op)
      1: if (r < 20 && c < 10) model[r][c] = w[18:16];
      2: model_clear();
      3: if (r < 20) for (int cc = 0; cc < 10; cc++) model[r][cc] = 3'd0;
      4: if (r < 20) begin
        for (int rr = r; rr > 0; rr--)
          for (int cc = 0; cc < 10; cc++) model[rr][cc] = model[rr-1][cc];
        for (int cc = 0; cc < 10; cc++) model[0][cc] = 3'd0;
      end
      default: ;
    endcase
  endtask

  function automatic logic [19:0] model_full();
    logic [19:0] f;
    for (int r = 0; r < 20; r++) begin
      f[r] = 1'b1;
      for (int c = 0; c < 10; c++) if (model[r][c] == 3'd0) f[r] = 1'b0;
    end
    return f;
  endfunction

  task automatic add(input string name, input int op, input int r, input int c,
                     input int color, input logic [1:0] st, input int busy);
    vec_t v;
    v.name = name;
    v.word = next_word(op, r, c, color);
    v.st   = st;
    v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input logic [1:0] st, input int busy);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.busy = busy;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and measures the busy run the DUT produces.
  // Optional hooks replace block_data at given busy-cycle counts.
  task automatic collect(input int h1, input logic [31:0] w1,
                         input int h2, input logic [31:0] w2);
    exp_t e;
    int   n;
    bit   done;
    n    = 0;
    done = 1'b0;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk_clk);
      if (drawing_status == 2'b01) begin
        n++;
        if (n == h1) block_data = w1;
        if (n == h2) block_data = w2;
      end else begin
        done = 1'b1;
      end
    end
    chk({e.name, " timeout"}, 32'(!done), 32'd0);
    chk({e.name, " status"}, 32'(drawing_status), 32'(e.st));
    chk({e.name, " busy"}, 32'(n), 32'(e.busy));
  endtask

  task automatic exec(input string name, input logic [31:0] w,
                      input logic [1:0] st, input int busy);
    @(negedge clk_clk);
    block_data = w;
    push_exp(name, st, busy);
    model_apply(w);
    collect(0, 32'h0, 0, 32'h0);
  endtask

  // Pipelined scan of all cells through the registered read port.
  task automatic check_board(input string name);
    int bad, first;
    bad   = 0;
    first = -1;
    for (int i = 0; i <= 200; i++) begin
      @(negedge clk_clk);
      if (i > 0) begin
        int p;
        p = i - 1;
        if (rd_color !== model[p/10][p%10]) begin
          bad++;
          if (first < 0) first = p;
        end
      end
      if (i < 200) begin
        rd_row = 5'(i / 10);
        rd_col = 4'(i % 10);
      end
    end
    if (bad != 0) $display("  first bad cell (%0d,%0d)", first / 10, first % 10);
    chk({name, " board bad cells"}, 32'(bad), 32'd0);
    chk({name, " full_rows"}, 32'(full_rows), 32'(model_full()));
  endtask

  task automatic rd_chk(input string name, input int r, input int c, input logic [2:0] exp);
    @(negedge clk_clk);
    rd_row = 5'(r);
    rd_col = 4'(c);
    @(negedge clk_clk);
    chk(name, 32'(rd_color), 32'(exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1, wa, wb;
    int          busy_seen, bad_st;

    reset_reset_n = 1'b0;
    block_data    = 32'h0;
    rd_row        = 5'd0;
    rd_col        = 4'd0;
    tgl           = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("reset status", 32'(drawing_status), 32'h0);
    chk("reset rd_color", 32'(rd_color), 32'h0);
    chk("reset full_rows", 32'(full_rows), 32'h0);

    add("wr5_3", 1, 5, 3, 6, 2'b10, 1);
    add("clear_board", 2, 0, 0, 0, 2'b10, 200);
    for (int c = 0; c < 10; c++) add($sformatf("row19_c%0d", c), 1, 19, c, 1, 2'b10, 1);
    add("wr18_0", 1, 18, 0, 2, 2'b10, 1);
    add("shift19", 4, 19, 0, 0, 2'b10, 200);
    add("wr_col12", 1, 2, 12, 5, 2'b11, 0);
    add("op6", 6, 0, 0, 0, 2'b11, 0);
    add("op7", 7, 1, 1, 1, 2'b11, 0);
    add("wr_row20", 1, 20, 0, 1, 2'b11, 0);
    add("clrrow25", 3, 25, 0, 0, 2'b11, 0);
    add("shift20", 4, 20, 0, 0, 2'b11, 0);
    add("nop", 0, 0, 0, 0, 2'b10, 0);
    add("wr0_0", 1, 0, 0, 7, 2'b10, 1);
    add("wr19_9", 1, 19, 9, 3, 2'b10, 1);
    add("shift0", 4, 0, 0, 0, 2'b10, 10);
    add("wr3_4", 1, 3, 4, 4, 2'b10, 1);
    add("wr2_4", 1, 2, 4, 5, 2'b10, 1);
    add("shift3", 4, 3, 0, 0, 2'b10, 40);
    add("clrrow19", 3, 19, 0, 0, 2'b10, 10);
    for (int c = 0; c < 10; c++) add($sformatf("row0_c%0d", c), 1, 0, c, 3, 2'b10, 1);
    add("clrrow0", 3, 0, 0, 0, 2'b10, 10);

    for (int i = 0; i < vecs.size(); i++) begin
      exec(vecs[i].name, vecs[i].word, vecs[i].st, vecs[i].busy);
      check_board(vecs[i].name);
    end

    // Toggle flipped and restored while busy: no new command.
    w0 = next_word(2, 0, 0, 0);
    wa = mk(~tgl, 1, 1, 1, 5);
    wb = mk(tgl, 1, 1, 1, 5);
    @(negedge clk_clk);
    block_data = w0;
    push_exp("dbl_flip_clear", 2'b10, 200);
    model_apply(w0);
    collect(50, wa, 60, wb);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk_clk);
      if (drawing_status != 2'b10) busy_seen++;
    end
    chk("dbl_flip no accept", 32'(busy_seen), 32'd0);
    check_board("dbl_flip");

    // Single flip while busy: accepted on the first IDLE cycle.
    w0 = next_word(2, 0, 0, 0);
    w1 = next_word(1, 7, 7, 2);
    @(negedge clk_clk);
    block_data = w0;
    push_exp("pend_clear", 2'b10, 200);
    push_exp("pend_write", 2'b10, 1);
    model_apply(w0);
    model_apply(w1);
    collect(50, w1, 0, 32'h0);
    collect(0, 32'h0, 0, 32'h0);
    check_board("pending");

    rd_chk("oor row20", 20, 0, 3'd0);
    rd_chk("oor col10", 7, 10, 3'd0);
    rd_chk("oor row31", 31, 15, 3'd0);
    rd_chk("cell7_7", 7, 7, 3'd2);

    // Reset in the middle of a row clear.
    exec("wr10_5", next_word(1, 10, 5, 4), 2'b10, 1);
    w0 = next_word(3, 10, 0, 0);
    @(negedge clk_clk);
    block_data = w0;
    repeat (4) @(negedge clk_clk);
    chk("clr_row busy pre-reset", 32'(drawing_status), 32'h1);
    reset_reset_n = 1'b0;
    block_data    = 32'h0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    model_clear();
    tgl = 1'b0;
    bad_st = 0;
    repeat (5) begin
      @(negedge clk_clk);
      if (drawing_status != 2'b00) bad_st++;
    end
    chk("post-reset status idle", 32'(bad_st), 32'd0);
    check_board("post-reset");
    exec("post-reset wr", next_word(1, 4, 9, 5), 2'b10, 1);
    check_board("post-reset wr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
